// File: rtl/ra_bist_sdr_march.sv
// March C- BIST sequencer and functional/BIST port mux for an SDR array with NRD read ports and one write port.
// Latency: mux is combinational; a march is 10*DEPTH RUN cycles, RD_LAT DRAIN cycles, then one DONE cycle.
// Backpressure: none; start is ignored while busy, abort returns to IDLE next cycle. Option: RA_BIST_FAIL_CNT_EN adds fail_cnt.
module ra_bist_sdr_march #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int NRD    = 2,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bist_start,
    input  logic              bist_abort,
    input  logic [DW-1:0]     bist_pat,
    input  logic [NRD-1:0]    rd_enb_in,
    input  logic [NRD*AW-1:0] rd_adr_in,
    input  logic              wr_enb_in,
    input  logic [AW-1:0]     wr_adr_in,
    input  logic [DW-1:0]     wr_dat_in,
    input  logic [NRD*DW-1:0] rd_dat,
    output logic [NRD-1:0]    rd_enb_out,
    output logic [NRD*AW-1:0] rd_adr_out,
    output logic              wr_enb_out,
    output logic [AW-1:0]     wr_adr_out,
    output logic [DW-1:0]     wr_dat_out,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [AW-1:0]     fail_adr,
    output logic [2:0]        fail_elem,
    output logic [NRD-1:0]    fail_port
`ifdef RA_BIST_FAIL_CNT_EN
    ,
    output logic [15:0]       fail_cnt
`endif
);

    localparam int            CW      = $clog2(RD_LAT + 1);
    localparam logic [AW-1:0] ADR_MAX = {AW{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    elem_q, elem_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          phase_q, phase_d;
    logic [CW-1:0] drain_q, drain_d;
    logic [DW-1:0] pat_q;

    logic          busy_w, start_go, abort_go, flush;
    logic          elem_down, elem_two_op, last_addr, op_done;
    logic          bist_rd, bist_wr;
    logic [DW-1:0] rd_exp, wr_word;

    assign busy_w   = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign start_go = (state_q == S_IDLE) && bist_start;
    assign abort_go = busy_w && bist_abort;
    assign flush    = start_go || abort_go;

    // Element decode: M0 w0, M1 r0w1, M2 r1w0 (up); M3 r0w1, M4 r1w0, M5 r0 (down).
    // phase_q selects the read (0) or write (1) cycle of a two-op element.
    always_comb begin
        elem_down   = (elem_q >= 3'd3);
        elem_two_op = (elem_q != 3'd0) && (elem_q != 3'd5);
        last_addr   = elem_down ? (addr_q == '0) : (addr_q == ADR_MAX);
        bist_rd     = (state_q == S_RUN) && (elem_q != 3'd0) && !phase_q;
        bist_wr     = (state_q == S_RUN) && ((elem_q == 3'd0) || (elem_two_op && phase_q));
        op_done     = !elem_two_op || phase_q;
        rd_exp      = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? ~pat_q : pat_q;
        wr_word     = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? ~pat_q : pat_q;
    end

    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        addr_d  = addr_q;
        phase_d = phase_q;
        drain_d = drain_q;
        unique case (state_q)
            S_IDLE: begin
                if (bist_start) begin
                    state_d = S_RUN;
                    elem_d  = 3'd0;
                    addr_d  = '0;
                    phase_d = 1'b0;
                end
            end
            S_RUN: begin
                if (bist_abort) begin
                    state_d = S_IDLE;
                end else if (!op_done) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (!last_addr) begin
                        addr_d = elem_down ? (addr_q - AW'(1)) : (addr_q + AW'(1));
                    end else if (elem_q == 3'd5) begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                    end else begin
                        // Next element starts at the bottom for M1/M2, at the top for M3..M5.
                        elem_d = elem_q + 3'd1;
                        addr_d = (elem_q >= 3'd2) ? ADR_MAX : '0;
                    end
                end
            end
            S_DRAIN: begin
                if (bist_abort) begin
                    state_d = S_IDLE;
                end else if (drain_q == CW'(RD_LAT - 1)) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            elem_q  <= '0;
            addr_q  <= '0;
            phase_q <= 1'b0;
            drain_q <= '0;
            pat_q   <= '0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            addr_q  <= addr_d;
            phase_q <= phase_d;
            drain_q <= drain_d;
            if (start_go) begin
                pat_q <= bist_pat;
            end
        end
    end

    // Expected word and tag travel alongside the array read so they line up with rd_dat.
    logic          pipe_vld  [RD_LAT];
    logic [DW-1:0] pipe_exp  [RD_LAT];
    logic [2:0]    pipe_elem [RD_LAT];
    logic [AW-1:0] pipe_adr  [RD_LAT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld[i]  <= 1'b0;
                pipe_exp[i]  <= '0;
                pipe_elem[i] <= '0;
                pipe_adr[i]  <= '0;
            end
        end else begin
            pipe_vld[0]  <= !flush && bist_rd;
            pipe_exp[0]  <= rd_exp;
            pipe_elem[0] <= elem_q;
            pipe_adr[0]  <= addr_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i]  <= !flush && pipe_vld[i-1];
                pipe_exp[i]  <= pipe_exp[i-1];
                pipe_elem[i] <= pipe_elem[i-1];
                pipe_adr[i]  <= pipe_adr[i-1];
            end
        end
    end

    logic [NRD-1:0] miss;
    logic           any_miss;

    always_comb begin
        miss = '0;
        for (int p = 0; p < NRD; p++) begin
            miss[p] = pipe_vld[RD_LAT-1] && (rd_dat[p*DW +: DW] != pipe_exp[RD_LAT-1]);
        end
        any_miss = (|miss) && !abort_go;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_adr  <= '0;
            fail_elem <= '0;
            fail_port <= '0;
        end else if (start_go) begin
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_adr  <= '0;
            fail_elem <= '0;
            fail_port <= '0;
        end else begin
            if ((state_q == S_DRAIN) && (state_d == S_DONE)) begin
                done <= 1'b1;
            end
            if (any_miss) begin
                fail <= 1'b1;
                if (!fail) begin
                    fail_adr  <= pipe_adr[RD_LAT-1];
                    fail_elem <= pipe_elem[RD_LAT-1];
                    fail_port <= miss;
                end
            end
        end
    end

`ifdef RA_BIST_FAIL_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fail_cnt <= '0;
        end else if (start_go) begin
            fail_cnt <= '0;
        end else if (any_miss && (fail_cnt != 16'hFFFF)) begin
            fail_cnt <= fail_cnt + 16'd1;
        end
    end
`endif

    always_comb begin
        if (busy_w) begin
            rd_enb_out = {NRD{bist_rd}};
            rd_adr_out = {NRD{addr_q}};
            wr_enb_out = bist_wr;
            wr_adr_out = addr_q;
            wr_dat_out = wr_word;
        end else begin
            rd_enb_out = rd_enb_in;
            rd_adr_out = rd_adr_in;
            wr_enb_out = wr_enb_in;
            wr_adr_out = wr_adr_in;
            wr_dat_out = wr_dat_in;
        end
    end

    assign busy = busy_w;

endmodule

// File: tb/tb_ra_bist_sdr_march.sv
// Bench for ra_bist_sdr_march: default instance (A) with a fault-injectable array model, small instance (B).
module tb_ra_bist_sdr_march;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DW=32, AW=5, NRD=2, RD_LAT=1
    logic        a_bist_start, a_bist_abort;
    logic [31:0] a_bist_pat;
    logic [1:0]  a_rd_enb_in;
    logic [9:0]  a_rd_adr_in;
    logic        a_wr_enb_in;
    logic [4:0]  a_wr_adr_in;
    logic [31:0] a_wr_dat_in;
    logic [63:0] a_rd_dat;
    logic [1:0]  a_rd_enb_out;
    logic [9:0]  a_rd_adr_out;
    logic        a_wr_enb_out;
    logic [4:0]  a_wr_adr_out;
    logic [31:0] a_wr_dat_out;
    logic        a_busy, a_done, a_fail;
    logic [4:0]  a_fail_adr;
    logic [2:0]  a_fail_elem;
    logic [1:0]  a_fail_port;
`ifdef RA_BIST_FAIL_CNT_EN
    logic [15:0] a_fail_cnt;
`endif

    ra_bist_sdr_march dut_a (
        .clk(clk), .reset(reset),
        .bist_start(a_bist_start), .bist_abort(a_bist_abort), .bist_pat(a_bist_pat),
        .rd_enb_in(a_rd_enb_in), .rd_adr_in(a_rd_adr_in),
        .wr_enb_in(a_wr_enb_in), .wr_adr_in(a_wr_adr_in), .wr_dat_in(a_wr_dat_in),
        .rd_dat(a_rd_dat),
        .rd_enb_out(a_rd_enb_out), .rd_adr_out(a_rd_adr_out),
        .wr_enb_out(a_wr_enb_out), .wr_adr_out(a_wr_adr_out), .wr_dat_out(a_wr_dat_out),
        .busy(a_busy), .done(a_done), .fail(a_fail),
        .fail_adr(a_fail_adr), .fail_elem(a_fail_elem), .fail_port(a_fail_port)
`ifdef RA_BIST_FAIL_CNT_EN
        , .fail_cnt(a_fail_cnt)
`endif
    );

    // Instance B: DW=16, AW=4, NRD=1, RD_LAT=2
    logic        b_bist_start, b_bist_abort;
    logic [15:0] b_bist_pat;
    logic [0:0]  b_rd_enb_in;
    logic [3:0]  b_rd_adr_in;
    logic        b_wr_enb_in;
    logic [3:0]  b_wr_adr_in;
    logic [15:0] b_wr_dat_in;
    logic [15:0] b_rd_dat;
    logic [0:0]  b_rd_enb_out;
    logic [3:0]  b_rd_adr_out;
    logic        b_wr_enb_out;
    logic [3:0]  b_wr_adr_out;
    logic [15:0] b_wr_dat_out;
    logic        b_busy, b_done, b_fail;
    logic [3:0]  b_fail_adr;
    logic [2:0]  b_fail_elem;
    logic [0:0]  b_fail_port;
`ifdef RA_BIST_FAIL_CNT_EN
    logic [15:0] b_fail_cnt;
`endif

    ra_bist_sdr_march #(.DW(16), .AW(4), .NRD(1), .RD_LAT(2)) dut_b (
        .clk(clk), .reset(reset),
        .bist_start(b_bist_start), .bist_abort(b_bist_abort), .bist_pat(b_bist_pat),
        .rd_enb_in(b_rd_enb_in), .rd_adr_in(b_rd_adr_in),
        .wr_enb_in(b_wr_enb_in), .wr_adr_in(b_wr_adr_in), .wr_dat_in(b_wr_dat_in),
        .rd_dat(b_rd_dat),
        .rd_enb_out(b_rd_enb_out), .rd_adr_out(b_rd_adr_out),
        .wr_enb_out(b_wr_enb_out), .wr_adr_out(b_wr_adr_out), .wr_dat_out(b_wr_dat_out),
        .busy(b_busy), .done(b_done), .fail(b_fail),
        .fail_adr(b_fail_adr), .fail_elem(b_fail_elem), .fail_port(b_fail_port)
`ifdef RA_BIST_FAIL_CNT_EN
        , .fail_cnt(b_fail_cnt)
`endif
    );

    // Array models. A: 1-cycle read, optional stuck-at-1 on addr 5 bit 3 seen by port 1 only.
    logic [31:0] mem_a [32];
    logic        stuck_en;

    function automatic logic [31:0] a_read(input logic [4:0] adr, input int p);
        logic [31:0] w;
        w = mem_a[adr];
        if (stuck_en && (p == 1) && (adr == 5'd5)) w[3] = 1'b1;
        return w;
    endfunction

    always @(posedge clk) begin
        if (a_wr_enb_out) mem_a[a_wr_adr_out] <= a_wr_dat_out;
        a_rd_dat <= {a_read(a_rd_adr_out[9:5], 1), a_read(a_rd_adr_out[4:0], 0)};
    end

    logic [15:0] mem_b [16];
    logic [15:0] b_p1;

    always @(posedge clk) begin
        if (b_wr_enb_out) mem_b[b_wr_adr_out] <= b_wr_dat_out;
        b_p1     <= mem_b[b_rd_adr_out];
        b_rd_dat <= b_p1;
    end

    typedef struct {
        string      tag;
        int         done_at;
        int         idle_at;
        int         busy_n;
        int         rd_n;
        int         wr_n;
        logic       fail;
        logic [4:0] adr;
        logic [2:0] elem;
        logic [1:0] port;
        int         cnt;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input string tag, input int done_at, input int idle_at, input int busy_n,
                        input int rd_n, input int wr_n, input logic f, input logic [4:0] adr,
                        input logic [2:0] elem, input logic [1:0] port, input int cnt);
        exp_t e;
        e.tag = tag; e.done_at = done_at; e.idle_at = idle_at; e.busy_n = busy_n;
        e.rd_n = rd_n; e.wr_n = wr_n; e.fail = f; e.adr = adr; e.elem = elem;
        e.port = port; e.cnt = cnt;
        sb.push_back(e);
    endtask

    // Cycle k is the k-th sample after the start edge; all breaks are tested before op counting.
    task automatic march_a(input logic [31:0] pat, input int abort_at, input int restart_at,
                           input int reset_at, output int done_at, output int idle_at,
                           output int busy_n, output int rd_n, output int wr_n, output logic pre_fail);
        done_at = -1; idle_at = -1; busy_n = 0; rd_n = 0; wr_n = 0; pre_fail = 1'b0;
        repeat (2) @(negedge clk);
        a_bist_pat   = pat;
        a_bist_start = 1'b1;
        @(posedge clk); #1;
        a_bist_start = 1'b0;
        a_bist_pat   = ~pat;
        for (int cyc = 1; cyc <= 1000; cyc++) begin
            if (a_done) begin done_at = cyc; break; end
            if ((abort_at > 0) && (cyc > abort_at) && !a_busy) begin idle_at = cyc; break; end
            if (cyc == reset_at) begin
                pre_fail = a_fail;
                reset = 1'b0;
                #1;
                idle_at = cyc;
                break;
            end
            if (a_busy) busy_n++;
            if (a_wr_enb_out) wr_n++;
            if (|a_rd_enb_out) rd_n++;
            a_bist_abort = (cyc == abort_at);
            a_bist_start = (cyc == restart_at);
            @(posedge clk); #1;
        end
        a_bist_abort = 1'b0;
        a_bist_start = 1'b0;
    endtask

    task automatic score_a(input int done_at, input int idle_at, input int busy_n,
                           input int rd_n, input int wr_n);
        exp_t e;
        e = sb.pop_front();
        check({e.tag, ".done_at"},   done_at,     e.done_at);
        check({e.tag, ".idle_at"},   idle_at,     e.idle_at);
        check({e.tag, ".busy_n"},    busy_n,      e.busy_n);
        check({e.tag, ".rd_n"},      rd_n,        e.rd_n);
        check({e.tag, ".wr_n"},      wr_n,        e.wr_n);
        check({e.tag, ".done"},      a_done,      (e.done_at > 0));
        check({e.tag, ".fail"},      a_fail,      e.fail);
        check({e.tag, ".fail_adr"},  a_fail_adr,  e.adr);
        check({e.tag, ".fail_elem"}, a_fail_elem, e.elem);
        check({e.tag, ".fail_port"}, a_fail_port, e.port);
`ifdef RA_BIST_FAIL_CNT_EN
        check({e.tag, ".fail_cnt"},  a_fail_cnt,  e.cnt);
`endif
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int   done_at, idle_at, busy_n, rd_n, wr_n;
    logic pre_fail;
    int   b_done_at, b_busy_n, b_rd_n, b_wr_n;
    logic [16:0] b_wr_c1, b_wr_c18;

    initial begin
        reset = 1'b0; stuck_en = 1'b0;
        a_bist_start = 1'b0; a_bist_abort = 1'b0; a_bist_pat = '0;
        a_rd_enb_in = '0; a_rd_adr_in = '0; a_wr_enb_in = 1'b0; a_wr_adr_in = '0; a_wr_dat_in = '0;
        b_bist_start = 1'b0; b_bist_abort = 1'b0; b_bist_pat = '0;
        b_rd_enb_in = '0; b_rd_adr_in = '0; b_wr_enb_in = 1'b0; b_wr_adr_in = '0; b_wr_dat_in = '0;
        repeat (2) @(posedge clk); #1;
        check("rst.busy", a_busy, 1'b0);
        check("rst.done", a_done, 1'b0);
        check("rst.fail", a_fail, 1'b0);
        check("rst.fail_adr", a_fail_adr, 5'd0);
        check("rst.fail_elem", a_fail_elem, 3'd0);
        check("rst.fail_port", a_fail_port, 2'b00);
        check("rst.b_busy", b_busy, 1'b0);
        @(negedge clk); reset = 1'b1;

        // Idle pass-through
        a_rd_enb_in = 2'b10; a_rd_adr_in = {5'd9, 5'd7};
        a_wr_enb_in = 1'b1; a_wr_adr_in = 5'd3; a_wr_dat_in = 32'hDEADBEEF;
        #1;
        check("pt.rd_enb", a_rd_enb_out, 2'b10);
        check("pt.rd_adr", a_rd_adr_out, {5'd9, 5'd7});
        check("pt.wr_enb", a_wr_enb_out, 1'b1);
        check("pt.wr_adr", a_wr_adr_out, 5'd3);
        check("pt.wr_dat", a_wr_dat_out, 32'hDEADBEEF);
        check("pt.busy", a_busy, 1'b0);
        // Functional traffic stays active during marches and must not reach the array.
        a_rd_enb_in = 2'b11;

        push("good", 322, -1, 321, 160, 160, 1'b0, 5'd0, 3'd0, 2'b00, 0);
        march_a(32'h0, 0, 0, 0, done_at, idle_at, busy_n, rd_n, wr_n, pre_fail);
        score_a(done_at, idle_at, busy_n, rd_n, wr_n);

        stuck_en = 1'b1;
        push("stuck", 322, -1, 321, 160, 160, 1'b1, 5'd5, 3'd1, 2'b10, 3);
        march_a(32'h0, 0, 0, 0, done_at, idle_at, busy_n, rd_n, wr_n, pre_fail);
        score_a(done_at, idle_at, busy_n, rd_n, wr_n);

        push("abort", -1, 101, 100, 34, 66, 1'b1, 5'd5, 3'd1, 2'b10, 1);
        march_a(32'h0, 100, 0, 0, done_at, idle_at, busy_n, rd_n, wr_n, pre_fail);
        score_a(done_at, idle_at, busy_n, rd_n, wr_n);
        check("abort.pt_rd_enb", a_rd_enb_out, 2'b11);
        check("abort.pt_wr_dat", a_wr_dat_out, 32'hDEADBEEF);

        stuck_en = 1'b0;
        push("rerun", 322, -1, 321, 160, 160, 1'b0, 5'd0, 3'd0, 2'b00, 0);
        march_a(32'h0, 0, 0, 0, done_at, idle_at, busy_n, rd_n, wr_n, pre_fail);
        score_a(done_at, idle_at, busy_n, rd_n, wr_n);

        push("restart", 322, -1, 321, 160, 160, 1'b0, 5'd0, 3'd0, 2'b00, 0);
        march_a(32'h0, 0, 50, 0, done_at, idle_at, busy_n, rd_n, wr_n, pre_fail);
        score_a(done_at, idle_at, busy_n, rd_n, wr_n);

        stuck_en = 1'b1;
        march_a(32'h0, 0, 0, 200, done_at, idle_at, busy_n, rd_n, wr_n, pre_fail);
        check("reset.reached", idle_at, 200);
        check("reset.pre_fail", pre_fail, 1'b1);
        check("reset.busy", a_busy, 1'b0);
        check("reset.fail", a_fail, 1'b0);
        check("reset.done", a_done, 1'b0);
        check("reset.fail_adr", a_fail_adr, 5'd0);
        check("reset.pt_wr_enb", a_wr_enb_out, 1'b1);
        check("reset.pt_rd_enb", a_rd_enb_out, 2'b11);
        @(negedge clk); reset = 1'b1;
        stuck_en = 1'b0;

        // Instance B march with a non-trivial background
        b_done_at = -1; b_busy_n = 0; b_rd_n = 0; b_wr_n = 0; b_wr_c1 = '0; b_wr_c18 = '0;
        repeat (2) @(negedge clk);
        b_bist_pat = 16'hA5A5; b_bist_start = 1'b1;
        @(posedge clk); #1;
        b_bist_start = 1'b0; b_bist_pat = 16'h0000;
        for (int cyc = 1; cyc <= 1000; cyc++) begin
            if (b_done) begin b_done_at = cyc; break; end
            if (b_busy) b_busy_n++;
            if (b_wr_enb_out) b_wr_n++;
            if (|b_rd_enb_out) b_rd_n++;
            if (cyc == 1)  b_wr_c1  = {b_wr_enb_out, b_wr_dat_out};
            if (cyc == 18) b_wr_c18 = {b_wr_enb_out, b_wr_dat_out};
            @(posedge clk); #1;
        end
        check("b.done_at", b_done_at, 163);
        check("b.busy_n", b_busy_n, 162);
        check("b.rd_n", b_rd_n, 80);
        check("b.wr_n", b_wr_n, 80);
        check("b.m0_wr", b_wr_c1, {1'b1, 16'hA5A5});
        check("b.m1_wr", b_wr_c18, {1'b1, 16'h5A5A});
        check("b.fail", b_fail, 1'b0);
        check("b.fail_adr", b_fail_adr, 4'd0);
        check("b.fail_elem", b_fail_elem, 3'd0);
        check("b.fail_port", b_fail_port, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
